// File: rtl/uart_fifo_pkg.sv
// Shared limits and Gray-code helpers for the UART RX dual-clock FIFO.
// The helpers work on the widest legal pointer; callers cast in and truncate out.
`timescale 1ns/1ps
package uart_fifo_pkg;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 4;
    localparam int DEPTH_MAX = 1024;
    localparam int PTR_MAX_W = $clog2(DEPTH_MAX) + 1;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits leave the lower-bit result unchanged, so narrow pointers convert correctly.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/uart_rx_async_fifo_prog_if.sv
// Write-side and read-side signal bundle of the UART RX dual-clock FIFO.
`timescale 1ns/1ps
interface uart_rx_async_fifo_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  WEi;
    logic [DATA_WIDTH-1:0] WDi;
    logic                  WERRi;
    logic                  WCLRi;
    logic [AW:0]           AFULL_THRi;
    logic                  FULLo;
    logic                  AFULLo;
    logic [AW:0]           WLVLo;
    logic                  OVFo;

    logic                  REi;
    logic [DATA_WIDTH-1:0] RDo;
    logic                  RERRo;
    logic                  RVALIDo;
    logic                  RCLRi;
    logic [AW:0]           AEMPTY_THRi;
    logic                  EMPTYo;
    logic                  AEMPTYo;
    logic [AW:0]           RLVLo;
    logic                  UNFo;

    modport master (
        output WEi, WDi, WERRi, WCLRi, AFULL_THRi,
        output REi, RCLRi, AEMPTY_THRi,
        input  FULLo, AFULLo, WLVLo, OVFo,
        input  RDo, RERRo, RVALIDo, EMPTYo, AEMPTYo, RLVLo, UNFo
    );

    modport slave (
        input  WEi, WDi, WERRi, WCLRi, AFULL_THRi,
        input  REi, RCLRi, AEMPTY_THRi,
        output FULLo, AFULLo, WLVLo, OVFo,
        output RDo, RERRo, RVALIDo, EMPTYo, AEMPTYo, RLVLo, UNFo
    );
endinterface

// File: rtl/uart_cdc_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering the clk domain.
`timescale 1ns/1ps
module uart_cdc_gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = gray_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign gray_out = stage_q[STAGES-1];
endmodule

// File: rtl/uart_rx_async_fifo_prog.sv
// Dual-clock FIFO between the UART receiver (WCLK) and the system bus (RCLK) with
// programmable thresholds, fill levels, sticky error flags and show-ahead or registered read.
`timescale 1ns/1ps
module uart_rx_async_fifo_prog
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic WCLK,
    input  logic WRST,
    input  logic RCLK,
    input  logic RRST,
    uart_rx_async_fifo_prog_if.slave bus
);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);

    generate
        if ((DEPTH < 4) || (DEPTH > DEPTH_MAX) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of 2 between 4 and 1024");
        end
        if ((SYNC_STAGES < SYNC_MIN) || (SYNC_STAGES > SYNC_MAX)) begin : g_bad_sync
            $error("SYNC_STAGES must be between 2 and 4");
        end
    endgenerate

    // ---------------- write domain ----------------
    logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_gray_wsync, rd_bin_wsync, wlvl;
    logic          ovf_q, ovf_d;
    logic          full, wr_accept;
    logic [EW-1:0] mem_q [DEPTH];

    always_comb begin
        rd_bin_wsync = PW'(gray2bin(ptr_wide_t'(rd_gray_wsync)));
        wlvl         = wr_bin_q - rd_bin_wsync;
        full         = (wlvl == DEPTH_LVL);
        wr_accept    = bus.WEi && !full;
        wr_bin_d     = wr_bin_q + PW'(wr_accept);
        wr_gray_d    = PW'(bin2gray(ptr_wide_t'(wr_bin_d)));
        // a dropped write wins over a same-edge clear
        ovf_d        = (bus.WEi && full) || (ovf_q && !bus.WCLRi);
    end

    always_ff @(posedge WCLK or posedge WRST) begin
        if (WRST) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge WCLK) begin
        if (wr_accept) begin
            mem_q[wr_bin_q[AW-1:0]] <= {bus.WERRi, bus.WDi};
        end
    end

    assign bus.FULLo  = full;
    assign bus.AFULLo = (wlvl >= bus.AFULL_THRi);
    assign bus.WLVLo  = wlvl;
    assign bus.OVFo   = ovf_q;

    // ---------------- pointer crossings ----------------
    logic [PW-1:0] rd_gray_q, wr_gray_rsync;

    uart_cdc_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd2w_sync (
        .clk      (WCLK),
        .rst      (WRST),
        .gray_in  (rd_gray_q),
        .gray_out (rd_gray_wsync)
    );

    uart_cdc_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_w2r_sync (
        .clk      (RCLK),
        .rst      (RRST),
        .gray_in  (wr_gray_q),
        .gray_out (wr_gray_rsync)
    );

    // ---------------- read domain ----------------
    logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_d;
    logic [PW-1:0] wr_bin_rsync, rlvl;
    logic          unf_q, unf_d;
    logic          empty, rd_accept;
    logic [EW-1:0] rd_word;

    always_comb begin
        wr_bin_rsync = PW'(gray2bin(ptr_wide_t'(wr_gray_rsync)));
        rlvl         = wr_bin_rsync - rd_bin_q;
        empty        = (rlvl == '0);
        rd_accept    = bus.REi && !empty;
        rd_bin_d     = rd_bin_q + PW'(rd_accept);
        rd_gray_d    = PW'(bin2gray(ptr_wide_t'(rd_bin_d)));
        unf_d        = (bus.REi && empty) || (unf_q && !bus.RCLRi);
    end

    always_ff @(posedge RCLK or posedge RRST) begin
        if (RRST) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            unf_q     <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            unf_q     <= unf_d;
        end
    end

    assign rd_word     = mem_q[rd_bin_q[AW-1:0]];
    assign bus.EMPTYo  = empty;
    assign bus.AEMPTYo = (rlvl <= bus.AEMPTY_THRi);
    assign bus.RLVLo   = rlvl;
    assign bus.UNFo    = unf_q;

    generate
        if (FWFT != 0) begin : g_show_ahead
            assign bus.RDo     = rd_word[DATA_WIDTH-1:0];
            assign bus.RERRo   = rd_word[DATA_WIDTH];
            assign bus.RVALIDo = 1'b0;
        end else begin : g_registered
            logic [EW-1:0] rword_q, rword_d;
            logic          rvalid_q, rvalid_d;

            // output holds its last word when no read is accepted
            always_comb begin
                rvalid_d = rd_accept;
                rword_d  = rd_accept ? rd_word : rword_q;
            end

            always_ff @(posedge RCLK or posedge RRST) begin
                if (RRST) begin
                    rword_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rword_q  <= rword_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign bus.RDo     = rword_q[DATA_WIDTH-1:0];
            assign bus.RERRo   = rword_q[DATA_WIDTH];
            assign bus.RVALIDo = rvalid_q;
        end
    endgenerate
endmodule

// File: tb/tb_uart_rx_async_fifo_prog.sv
// Directed bench for the UART RX dual-clock FIFO: show-ahead instance for fill/drain/wrap/reset,
// registered-read instance for error tag and read latency.
`timescale 1ns/1ps
module tb_uart_rx_async_fifo_prog;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic    WCLK = 1'b0;
    logic    RCLK = 1'b0;
    logic    WRST = 1'b1;
    logic    RRST = 1'b1;
    realtime w_half = 10.0;
    realtime r_half = 15.0;

    always begin #(w_half); WCLK = ~WCLK; end
    always begin #(r_half); RCLK = ~RCLK; end

    uart_rx_async_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_a ();
    uart_rx_async_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_b ();

    uart_rx_async_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .FWFT(1)) u_dut (
        .WCLK (WCLK), .WRST (WRST), .RCLK (RCLK), .RRST (RRST), .bus (bus_a)
    );

    uart_rx_async_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .FWFT(0)) u_dut_reg (
        .WCLK (WCLK), .WRST (WRST), .RCLK (RCLK), .RRST (RRST), .bus (bus_b)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [8:0] q[$];
    int         wr_n, rd_n, wcyc, rcyc, k, lvl;
    logic [8:0] word, exp_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_empty"},  32'(bus_a.EMPTYo),  1);
        check({tag, "_full"},   32'(bus_a.FULLo),   0);
        check({tag, "_afull"},  32'(bus_a.AFULLo),  0);
        check({tag, "_aempty"}, 32'(bus_a.AEMPTYo), 1);
        check({tag, "_wlvl"},   32'(bus_a.WLVLo),   0);
        check({tag, "_rlvl"},   32'(bus_a.RLVLo),   0);
        check({tag, "_ovf"},    32'(bus_a.OVFo),    0);
        check({tag, "_unf"},    32'(bus_a.UNFo),    0);
        check({tag, "_rvalid"}, 32'(bus_a.RVALIDo), 0);
        check({tag, "_b_rd"},   32'(bus_b.RDo),     0);
        check({tag, "_b_rerr"}, 32'(bus_b.RERRo),   0);
        check({tag, "_b_rvld"}, 32'(bus_b.RVALIDo), 0);
        check({tag, "_b_empty"},32'(bus_b.EMPTYo),  1);
    endtask

    initial begin
        bus_a.WEi = 0; bus_a.WDi = '0; bus_a.WERRi = 0; bus_a.WCLRi = 0; bus_a.REi = 0; bus_a.RCLRi = 0;
        bus_a.AFULL_THRi = 5'd15; bus_a.AEMPTY_THRi = 5'd1;
        bus_b.WEi = 0; bus_b.WDi = '0; bus_b.WERRi = 0; bus_b.WCLRi = 0; bus_b.REi = 0; bus_b.RCLRi = 0;
        bus_b.AFULL_THRi = 5'd15; bus_b.AEMPTY_THRi = 5'd1;

        // 1. reset
        repeat (3) @(posedge RCLK);
        @(negedge WCLK);
        WRST = 0; RRST = 0;
        #1;
        check_reset_a("reset");

        // 2. fill 17 words: 16 stored, 17th dropped
        for (int i = 0; i < 17; i++) begin
            @(negedge WCLK);
            if (i == 16) begin
                check("ovf_before_drop", 32'(bus_a.OVFo), 0);
                check("full_before_drop", 32'(bus_a.FULLo), 1);
            end
            bus_a.WEi = 1; bus_a.WDi = 8'(i); bus_a.WERRi = 0;
            @(negedge WCLK);
            bus_a.WEi = 0;
            lvl = (i < 16) ? i + 1 : 16;
            check($sformatf("fill_wlvl_%0d", i), 32'(bus_a.WLVLo), 32'(lvl));
            check($sformatf("fill_full_%0d", i), 32'(bus_a.FULLo), 32'(lvl == 16));
            check($sformatf("fill_afull_%0d", i), 32'(bus_a.AFULLo), 32'(lvl >= 15));
        end
        check("ovf_set", 32'(bus_a.OVFo), 1);
        @(negedge WCLK); bus_a.WCLRi = 1;
        @(negedge WCLK); bus_a.WCLRi = 0;
        check("ovf_cleared", 32'(bus_a.OVFo), 0);
        check("full_after_clr", 32'(bus_a.FULLo), 1);

        // 3. drain in show-ahead mode
        k = 0;
        while (bus_a.RLVLo != 5'd16 && k < 20) begin @(negedge RCLK); k++; end
        check("rlvl_sees_full", 32'(bus_a.RLVLo), 16);
        for (int i = 0; i < 16; i++) begin
            @(negedge RCLK);
            check($sformatf("drain_rd_%0d", i), 32'(bus_a.RDo), 32'(i));
            check($sformatf("drain_rlvl_%0d", i), 32'(bus_a.RLVLo), 32'(16 - i));
            check($sformatf("drain_aempty_%0d", i), 32'(bus_a.AEMPTYo), 32'((16 - i) <= 1));
            bus_a.REi = 1;
        end
        @(negedge RCLK); bus_a.REi = 0;
        check("drain_empty", 32'(bus_a.EMPTYo), 1);
        check("drain_rlvl0", 32'(bus_a.RLVLo), 0);
        check("drain_unf_clear", 32'(bus_a.UNFo), 0);
        bus_a.REi = 1;
        @(negedge RCLK); bus_a.REi = 0;
        check("unf_set", 32'(bus_a.UNFo), 1);
        check("unf_rlvl0", 32'(bus_a.RLVLo), 0);
        check("unf_empty", 32'(bus_a.EMPTYo), 1);
        bus_a.RCLRi = 1;
        @(negedge RCLK); bus_a.RCLRi = 0;
        check("unf_cleared", 32'(bus_a.UNFo), 0);
        k = 0;
        while (bus_a.WLVLo != 5'd0 && k < 20) begin @(negedge WCLK); k++; end
        check("wlvl_freed", 32'(bus_a.WLVLo), 0);
        check("full_freed", 32'(bus_a.FULLo), 0);

        // 4. error tag and registered-read latency
        @(negedge WCLK);
        bus_b.WEi = 1; bus_b.WDi = 8'hA5; bus_b.WERRi = 1;
        @(posedge WCLK); #1;
        bus_b.WEi = 0; bus_b.WERRi = 0;
        k = 0;
        while (bus_b.EMPTYo && k < 10) begin @(posedge RCLK); #1; k++; end
        check("reg_empty_fell", 32'(bus_b.EMPTYo), 0);
        check("reg_empty_within_3", 32'(k <= 3), 1);
        @(negedge RCLK);
        check("reg_rvalid_idle", 32'(bus_b.RVALIDo), 0);
        check("reg_rd_idle", 32'(bus_b.RDo), 0);
        bus_b.REi = 1;
        @(negedge RCLK); bus_b.REi = 0;
        check("reg_rvalid", 32'(bus_b.RVALIDo), 1);
        check("reg_rd", 32'(bus_b.RDo), 32'hA5);
        check("reg_rerr", 32'(bus_b.RERRo), 1);
        check("reg_empty_after", 32'(bus_b.EMPTYo), 1);
        @(negedge RCLK);
        check("reg_rvalid_drop", 32'(bus_b.RVALIDo), 0);
        check("reg_rd_hold", 32'(bus_b.RDo), 32'hA5);
        check("fwft_rvalid_tied", 32'(bus_a.RVALIDo), 0);

        // 5. random concurrent traffic with clock ratio change midway
        q.delete();
        wr_n = 0; rd_n = 0; wcyc = 0; rcyc = 0;
        fork
            begin
                while (wr_n < 1000 && wcyc < 30000) begin
                    @(negedge WCLK); wcyc++;
                    bus_a.WEi = 0;
                    check("full_vs_occupancy", 32'(!bus_a.FULLo && q.size() >= DEPTH), 0);
                    if (wr_n == 500) begin w_half = 18.5; r_half = 11.5; end
                    if (!bus_a.FULLo && $urandom_range(0, 99) < 60) begin
                        word = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
                        bus_a.WEi = 1; bus_a.WDi = word[7:0]; bus_a.WERRi = word[8];
                        @(posedge WCLK);
                        q.push_back(word);
                        wr_n++;
                    end
                end
                @(negedge WCLK); bus_a.WEi = 0;
                check("wr_count", 32'(wr_n), 1000);
            end
            begin
                while (rd_n < 1000 && rcyc < 40000) begin
                    @(negedge RCLK); rcyc++;
                    bus_a.REi = 0;
                    check("empty_vs_occupancy", 32'(!bus_a.EMPTYo && q.size() == 0), 0);
                    if (!bus_a.EMPTYo && q.size() != 0 && $urandom_range(0, 99) < 55) begin
                        exp_word = q[0];
                        check($sformatf("wrap_rd_%0d", rd_n), 32'({bus_a.RERRo, bus_a.RDo}), 32'(exp_word));
                        bus_a.REi = 1;
                        @(posedge RCLK);
                        void'(q.pop_front());
                        rd_n++;
                    end
                end
                @(negedge RCLK); bus_a.REi = 0;
                check("rd_count", 32'(rd_n), 1000);
            end
        join
        check("wrap_empty_end", 32'(bus_a.EMPTYo), 1);

        // 6. mid-stream reset with 7 stored entries
        for (int i = 0; i < 7; i++) begin
            @(negedge WCLK);
            bus_a.WEi = 1; bus_a.WDi = 8'(8'h50 + i); bus_a.WERRi = 1;
        end
        @(negedge WCLK); bus_a.WEi = 0;
        check("mid_wlvl7", 32'(bus_a.WLVLo), 7);
        k = 0;
        while (bus_a.RLVLo != 5'd7 && k < 20) begin @(negedge RCLK); k++; end
        check("mid_rlvl7", 32'(bus_a.RLVLo), 7);
        #3;
        WRST = 1; RRST = 1;
        repeat (3) @(posedge WCLK);
        repeat (3) @(posedge RCLK);
        @(negedge WCLK);
        WRST = 0; RRST = 0;
        #1;
        check_reset_a("midrst");
        @(negedge WCLK);
        bus_a.WEi = 1; bus_a.WDi = 8'h3C; bus_a.WERRi = 0;
        @(negedge WCLK); bus_a.WEi = 0;
        k = 0;
        while (bus_a.EMPTYo && k < 20) begin @(negedge RCLK); k++; end
        check("post_rst_empty", 32'(bus_a.EMPTYo), 0);
        check("post_rst_rd", 32'(bus_a.RDo), 32'h3C);
        check("post_rst_rerr", 32'(bus_a.RERRo), 0);
        check("post_rst_rlvl", 32'(bus_a.RLVLo), 1);
        bus_a.REi = 1;
        @(negedge RCLK); bus_a.REi = 0;
        check("post_rst_drained", 32'(bus_a.EMPTYo), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_async_fifo_prog.md
# uart_rx_async_fifo_prog

Parametrised dual-clock FIFO between the UART receiver (write domain) and the system bus (read domain). It is the successor to the fixed UART RX FIFO and adds:
- configurable synchroniser depth
- selectable show-ahead or registered read mode
- a per-entry error bit
- fill-level outputs, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags

## Interface
- DATA_WIDTH, 8: payload width per entry.
- DEPTH, 16: entry count; power of 2, 4..1024.
- SYNC_STAGES, 2: pointer synchroniser flops per direction, 2..4.
- FWFT, 1: 1 = show-ahead read; 0 = registered read with 1-cycle latency.
- AW, $clog2(DEPTH): derived; pointers and levels are AW+1 bits.
- WCLK  in  1  write clock.
- WRST  in  1  write-domain reset, asynchronous, active-high.
- RCLK  in  1  read clock.
- RRST  in  1  read-domain reset, asynchronous, active-high.
- WEi  in  1  write request.
- WDi  in  DATA_WIDTH  write data.
- WERRi  in  1  error tag (parity/framing) stored with the entry.
- WCLRi  in  1  clears OVFo.
- AFULL_THRi  in  AW+1  almost-full threshold; quasi-static.
- FULLo  out  1  no free entry.
- AFULLo  out  1  WLVLo >= AFULL_THRi.
- WLVLo  out  AW+1  write-side fill level, 0..DEPTH.
- OVFo  out  1  sticky: a write was dropped.
- REi  in  1  read/pop request.
- RDo  out  DATA_WIDTH  read data.
- RERRo  out  1  error tag of RDo.
- RVALIDo  out  1  FWFT=0 only: RDo/RERRo valid this cycle; tied 0 when FWFT=1.
- RCLRi  in  1  clears UNFo.
- AEMPTY_THRi  in  AW+1  almost-empty threshold; quasi-static.
- EMPTYo  out  1  no readable entry.
- AEMPTYo  out  1  RLVLo <= AEMPTY_THRi.
- RLVLo  out  AW+1  read-side fill level.
- UNFo  out  1  sticky: a read hit an empty FIFO.

## Operation
- Storage holds DEPTH entries of {WERRi, WDi}. Binary pointers are AW+1 bits; the MSB is the wrap bit.
- **Write:** WEi && !FULLo stores at wr_ptr[AW-1:0] and increments wr_ptr. WEi && FULLo drops the word and sets OVFo.
- **Read:** REi && !EMPTYo increments rd_ptr. REi && EMPTYo changes no pointer and sets UNFo.
- **Pointer crossing:** pointers cross domains as Gray code through SYNC_STAGES flops, then convert back to binary.
- **Levels (modulo 2^(AW+1) subtraction, AW+1 bits):**
  - WLVLo = wr_ptr − rd_ptr_sync_bin
  - RLVLo = wr_ptr_sync_bin − rd_ptr
- **Flags:**
  - FULLo = (WLVLo == DEPTH)
  - EMPTYo = (RLVLo == 0)
  - Thresholds of 0 or >= DEPTH are legal; the compare is literal.
- **FWFT=1:** RDo/RERRo continuously show mem[rd_ptr] and are valid whenever !EMPTYo. REi pops.
- **FWFT=0:** an accepted read loads mem[rd_ptr] into output registers, and RVALIDo is 1 on the next RCLK cycle. Otherwise RVALIDo = 0 and RDo holds its value.
- **Sticky flags:** set and clear on the same edge resolves to set, on both sides.
- **Reset:** WRST and RRST must be asserted together. Resetting one side alone is unsupported; the bench never does it.
- **Reset values:**
  - FULLo = 0, AFULLo = (0 >= AFULL_THRi), WLVLo = 0, OVFo = 0
  - EMPTYo = 1, AEMPTYo = 1, RLVLo = 0, UNFo = 0
  - RDo = 0, RERRo = 0, RVALIDo = 0 (FWFT=0 registers)
  - Memory is not reset.

## Timing
- A write on WCLK edge n appears at the read side (EMPTYo falls, RLVLo increments) within SYNC_STAGES+1 RCLK edges.
- A pop frees its slot at the write side (FULLo falls) within SYNC_STAGES+1 WCLK edges.
- Flags and levels are combinational from registered local pointers and synchronised remote pointers. FULLo and EMPTYo respond to a local operation on the same edge.
- Remote-side views are pessimistic but never wrong: they may show fuller (write side) or emptier (read side) than the true state.
- Wrap-around: the pointer MSB toggles every DEPTH operations. Full and empty stay distinct across the wrap.
- Simultaneous write and read in their own domains are always legal, including write at full and read at empty.

## Structure
- Package uart_fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width via a parameterised class or typed wrapper.
  - localparam limits: SYNC_MIN=2, SYNC_MAX=4.
- Sub-module uart_cdc_gray_sync (WIDTH, STAGES): async-reset flop chain. It is instantiated twice, once per crossing direction.
- Elaboration-time assertions enforce that DEPTH is a power of 2 and that SYNC_STAGES is in range.

## Test plan
Default configuration: DEPTH=16, SYNC_STAGES=2, WCLK 50 MHz, RCLK 33 MHz, AFULL_THRi=15, AEMPTY_THRi=1.

1. **Reset:** hold WRST/RRST for 3 cycles -> EMPTYo=1, FULLo=0, WLVLo=RLVLo=0, OVFo=UNFo=0, RVALIDo=0.
2. **Fill and overflow:** write 0x00..0x10 (17 words) -> FULLo after the 16th; the 17th is dropped and OVFo=1. AFULLo is 1 from WLVLo=15. WCLRi clears OVFo.
3. **Drain, FWFT=1:** pop 16 words -> RDo sequence 0x00..0x0F. EMPTYo=1 after the last pop. One further REi sets UNFo=1 and RLVLo stays 0.
4. **Error tag and latency, FWFT=0:** write 0xA5 with WERRi=1. EMPTYo falls within 3 RCLK edges. REi gives RVALIDo=1, RDo=0xA5, RERRo=1 exactly one RCLK later.
5. **Wrap-around:** random concurrent traffic of 1000 words through a reference queue, using non-integer clock ratios in both directions -> data order exact, and FULLo/EMPTYo never violate the true occupancy.
6. **Mid-stream reset:** with 7 entries stored, pulse both resets -> all outputs return to reset values. The next written word is the first one read.
